// File: rtl/alu_pkg.sv
// Shared types for the serial ALU: operation codes, FSM states and a counter-width helper.
package alu_pkg;

    typedef enum logic [1:0] {
        OP_NAND = 2'b00,
        OP_NOR  = 2'b01,
        OP_ADD  = 2'b10,
        OP_SUB  = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // Slice counter needs at least one bit even when a single slice covers the word.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/alu_slice.sv
// Combinational SLICE-bit ALU cell: NAND/NOR/ADD/SUB with carry-in, carry-out and MSB carry-in.
module alu_slice
    import alu_pkg::*;
#(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a_s,
    input  logic [SLICE-1:0] b_s,
    input  logic             cin,
    input  op_t              s_op,
    output logic [SLICE-1:0] z_s,
    output logic             cout,
    output logic             c_msb
);

    logic [SLICE-1:0] b_eff;
    logic [SLICE:0]   sum;

    always_comb begin
        b_eff = (s_op == OP_SUB) ? ~b_s : b_s;
        sum   = {1'b0, a_s} + {1'b0, b_eff} + {{SLICE{1'b0}}, cin};
        cout  = sum[SLICE];
        // The sum bit at the MSB is a ^ b ^ carry_in, so the carry into it falls out directly.
        c_msb = sum[SLICE-1] ^ a_s[SLICE-1] ^ b_eff[SLICE-1];
        case (s_op)
            OP_NAND: z_s = ~(a_s & b_s);
            OP_NOR:  z_s = ~(a_s | b_s);
            default: z_s = sum[SLICE-1:0];
        endcase
    end

endmodule

// File: rtl/alu_serial.sv
// Multi-cycle ALU: evaluates WIDTH-bit operands SLICE bits per cycle, LSB slice first,
// with valid/ready handshakes on both sides and carry/overflow/zero status.
module alu_serial
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [1:0]       s_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int N     = WIDTH / SLICE;
    localparam int CNT_W = cnt_width(N);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    op_t              op_r;
    logic             carry;

    logic [SLICE-1:0] a_sl;
    logic [SLICE-1:0] b_sl;
    logic [SLICE-1:0] z_sl;
    logic             sl_cout;
    logic             sl_cmsb;
    logic             accept;
    logic             last;

    assign accept    = in_valid && in_ready;
    assign last      = (cnt == LAST);
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign zero      = (z == '0);

    assign a_sl = a_r[32'(cnt) * SLICE +: SLICE];
    assign b_sl = b_r[32'(cnt) * SLICE +: SLICE];

    alu_slice #(
        .SLICE (SLICE)
    ) u_slice (
        .a_s   (a_sl),
        .b_s   (b_sl),
        .cin   (carry),
        .s_op  (op_r),
        .z_s   (z_sl),
        .cout  (sl_cout),
        .c_msb (sl_cmsb)
    );

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid) state_nx = RUN;
            RUN:     if (last) state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Operands only feed the datapath, so they need no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_r  <= a;
            b_r  <= b;
            op_r <= op_t'(s_op);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            carry <= 1'b0;
            z     <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        carry <= cin;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    z[32'(cnt) * SLICE +: SLICE] <= z_sl;
                    carry <= sl_cout;
                    if (last) begin
                        // op_r[1] distinguishes ADD/SUB from the logic ops.
                        cout <= op_r[1] & sl_cout;
                        ovf  <= op_r[1] & (sl_cout ^ sl_cmsb);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) cnt <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_serial.sv
// Scoreboard bench for alu_serial: WIDTH=8/SLICE=2 and WIDTH=16/SLICE=16 instances side by side.
module tb_alu_serial;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        cin = 1'b0;
    logic [1:0]  s_op = 2'b00;
    logic        iv0 = 1'b0;
    logic        iv1 = 1'b0;
    logic        rdy = 1'b1;

    logic        ir0, ov0, co0, of0, zr0;
    logic [7:0]  z0;
    logic        ir1, ov1, co1, of1, zr1;
    logic [15:0] z1;

    always #5 clk = ~clk;

    alu_serial #(.WIDTH(8), .SLICE(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0),
        .a(a[7:0]), .b(b[7:0]), .cin(cin), .s_op(s_op),
        .out_valid(ov0), .out_ready(rdy), .z(z0), .cout(co0), .ovf(of0), .zero(zr0)
    );

    alu_serial #(.WIDTH(16), .SLICE(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1),
        .a(a), .b(b), .cin(cin), .s_op(s_op),
        .out_valid(ov1), .out_ready(rdy), .z(z1), .cout(co1), .ovf(of1), .zero(zr1)
    );

    typedef struct {
        logic [15:0] z;
        logic        cout;
        logic        ovf;
        logic        zero;
        int          acc;
        string       name;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;
    int last_handoff[2] = '{0, 0};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        vectors++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
        end
    endtask

    // Monitor: latency is measured from the negedge before the accept edge,
    // so the accept edge itself counts as the first of N+1 edges.
    logic        pv[2]   = '{1'b0, 1'b0};
    logic        prdy[2] = '{1'b1, 1'b1};
    logic [17:0] hobs[2] = '{18'h0, 18'h0};

    always @(negedge clk) begin : monitor
        logic        v;
        logic        ir;
        logic        zr;
        logic [17:0] obs;
        int          lat;
        int          qn;
        exp_t        head;
        for (int i = 0; i < 2; i++) begin
            v   = (i == 0) ? ov0 : ov1;
            ir  = (i == 0) ? ir0 : ir1;
            zr  = (i == 0) ? zr0 : zr1;
            obs = (i == 0) ? {8'h00, z0, co0, of0} : {z1, co1, of1};
            lat = (i == 0) ? 5 : 2;
            qn  = (i == 0) ? q0.size() : q1.size();
            if (v) begin
                chk("in_ready_low_in_done", 32'(ir), 32'd0);
                if (!pv[i]) begin
                    if (qn == 0) begin
                        chk("unexpected_out_valid", 32'd1, 32'd0);
                    end else begin
                        head = (i == 0) ? q0[0] : q1[0];
                        chk({head.name, "_latency"}, 32'(cyc - head.acc), 32'(lat));
                    end
                end else if (!prdy[i]) begin
                    chk("held_result_stable", 32'(obs), 32'(hobs[i]));
                end
                if (rdy && qn > 0) begin
                    if (i == 0) head = q0.pop_front();
                    else        head = q1.pop_front();
                    chk({head.name, "_z"},    32'(obs[17:2]), 32'(head.z));
                    chk({head.name, "_cout"}, 32'(obs[1]),    32'(head.cout));
                    chk({head.name, "_ovf"},  32'(obs[0]),    32'(head.ovf));
                    chk({head.name, "_zero"}, 32'(zr),        32'(head.zero));
                    last_handoff[i] = cyc;
                end
            end
            pv[i]   = v;
            prdy[i] = rdy;
            hobs[i] = obs;
        end
    end

    task automatic issue(input int sel, input logic [15:0] ta, input logic [15:0] tb_v,
                         input logic tcin, input op_t top, input logic [15:0] ez,
                         input logic ec, input logic eo, input string nm,
                         input bit track, input bit after);
        exp_t e;
        bit   got;
        got  = 1'b0;
        a    = ta;
        b    = tb_v;
        cin  = tcin;
        s_op = top;
        if (sel == 0) iv0 = 1'b1;
        else          iv1 = 1'b1;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            if ((sel == 0) ? ir0 : ir1) begin
                got    = 1'b1;
                e.z    = ez;
                e.cout = ec;
                e.ovf  = eo;
                e.zero = (ez == 16'h0);
                e.acc  = cyc;
                e.name = nm;
                if (track) begin
                    if (sel == 0) q0.push_back(e);
                    else          q1.push_back(e);
                end
                if (after) chk({nm, "_accept_after_handoff"}, 32'(cyc > last_handoff[sel]), 32'd1);
            end
            @(posedge clk);
            #1;
        end
        iv0 = 1'b0;
        iv1 = 1'b0;
        if (!got) chk({nm, "_accept_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic drain(input string nm);
        for (int k = 0; k < 100 && (q0.size() + q1.size()) != 0; k++) @(negedge clk);
        chk({nm, "_drained"}, 32'(q0.size() + q1.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stimulus
        int seen;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(ov0), 32'd0);
        chk("rst_in_ready",  32'(ir0), 32'd1);
        chk("rst_zero",      32'(zr0), 32'd1);
        chk("rst_z",         32'(z0),  32'd0);
        chk("rst_flags",     32'({co0, of0}), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        issue(0, 16'h7F, 16'h01, 1'b0, OP_ADD,  16'h80, 1'b0, 1'b1, "add_7f_01", 1, 0);
        issue(0, 16'h05, 16'h05, 1'b1, OP_SUB,  16'h00, 1'b1, 1'b0, "sub_05_05", 1, 0);
        issue(0, 16'h00, 16'h01, 1'b1, OP_SUB,  16'hFF, 1'b0, 1'b0, "sub_00_01", 1, 0);
        issue(0, 16'h80, 16'h80, 1'b0, OP_ADD,  16'h00, 1'b1, 1'b1, "add_80_80", 1, 0);
        issue(0, 16'hF0, 16'hCC, 1'b0, OP_NAND, 16'h3F, 1'b0, 1'b0, "nand_f0_cc", 1, 0);
        issue(0, 16'hF0, 16'h0F, 1'b0, OP_NOR,  16'h00, 1'b0, 1'b0, "nor_f0_0f", 1, 0);
        issue(0, 16'h12, 16'h34, 1'b1, OP_ADD,  16'h47, 1'b0, 1'b0, "add_12_34_c", 1, 0);
        issue(0, 16'h80, 16'h01, 1'b1, OP_SUB,  16'h7F, 1'b1, 1'b1, "sub_80_01", 1, 0);
        issue(0, 16'hFF, 16'hFF, 1'b1, OP_NAND, 16'h00, 1'b0, 1'b0, "nand_ff_ff", 1, 0);
        drain("basic");

        // Backpressure: result held for three cycles while new operands wait.
        rdy = 1'b0;
        issue(0, 16'h0F, 16'h01, 1'b0, OP_ADD, 16'h10, 1'b0, 1'b0, "bp_first", 1, 0);
        fork
            issue(0, 16'h20, 16'h22, 1'b0, OP_ADD, 16'h42, 1'b0, 1'b0, "bp_second", 1, 1);
            begin
                for (int k = 0; k < 50 && !ov0; k++) @(negedge clk);
                chk("bp_valid_seen", 32'(ov0), 32'd1);
                repeat (3) @(posedge clk);
                #1;
                rdy = 1'b1;
            end
        join
        drain("backpressure");

        // Reset in RUN cycle 2 of 0xFF + 0x01; that operation must never be reported.
        issue(0, 16'hFF, 16'h01, 1'b0, OP_ADD, 16'h00, 1'b1, 1'b0, "rst_mid", 0, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(ov0), 32'd0);
        chk("midrst_in_ready",  32'(ir0), 32'd1);
        chk("midrst_zero",      32'(zr0), 32'd1);
        chk("midrst_z",         32'(z0),  32'd0);
        chk("midrst_flags",     32'({co0, of0}), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (ov0) seen++;
        end
        chk("midrst_no_valid_after", 32'(seen), 32'd0);
        @(posedge clk);
        #1;
        issue(0, 16'h01, 16'h01, 1'b0, OP_ADD, 16'h02, 1'b0, 1'b0, "post_rst_add", 1, 0);
        drain("post_reset");

        issue(1, 16'hFFFF, 16'h0001, 1'b0, OP_ADD, 16'h0000, 1'b1, 1'b0, "w16_add_ffff", 1, 0);
        issue(1, 16'h8000, 16'h0001, 1'b1, OP_SUB, 16'h7FFF, 1'b1, 1'b1, "w16_sub_8000", 1, 0);
        issue(1, 16'h1234, 16'h00FF, 1'b0, OP_NOR, 16'hED00, 1'b0, 1'b0, "w16_nor", 1, 0);
        drain("wide");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
